// File: rtl/axis_reg_chain.sv
// Cascaded valid/ready register slices: transparent, forward-registered or skid-buffered.
// Define AXIS_REG_CHAIN_LEVEL_EN to add the level_o occupancy counter port.
module axis_reg_chain #(
   parameter int DataWidth = 16,
   parameter int Stages    = 2,
   parameter int Mode      = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [DataWidth-1:0] s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic                 m_ready_i,
   output logic                 m_valid_o,
   output logic [DataWidth-1:0] m_data_o
`ifdef AXIS_REG_CHAIN_LEVEL_EN
   ,
   output logic [$clog2(2*Stages+1)-1:0] level_o
`endif
);

   generate
      if (Mode == 0) begin : g_wire
         assign m_valid_o = s_valid_i;
         assign m_data_o  = s_data_i;
         assign s_ready_o = m_ready_i;
      end else if (Mode == 1) begin : g_fwd
         logic                 vld [Stages];
         logic [DataWidth-1:0] dat [Stages];
         logic                 rdy [Stages];

         // Ready ripples back from the sink through every slice in one cycle.
         always_comb begin : ready_chain
            logic r;
            r = m_ready_i;
            for (int k = Stages - 1; k >= 0; k--) begin
               r      = !vld[k] || r;
               rdy[k] = r;
            end
         end

         for (genvar k = 0; k < Stages; k++) begin : g_stage
            logic                 in_vld;
            logic [DataWidth-1:0] in_dat;
            logic                 vld_q;
            logic [DataWidth-1:0] dat_q;

            if (k == 0) begin : g_head
               assign in_vld = s_valid_i;
               assign in_dat = s_data_i;
            end else begin : g_body
               assign in_vld = vld[k-1];
               assign in_dat = dat[k-1];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
               if (rst_i) begin
                  vld_q <= 1'b0;
                  dat_q <= '0;
               end else if (flush_i) begin
                  vld_q <= 1'b0;
               end else if (rdy[k]) begin
                  vld_q <= in_vld;
                  if (in_vld) dat_q <= in_dat;
               end
            end

            assign vld[k] = vld_q;
            assign dat[k] = dat_q;
         end

         assign s_ready_o = rdy[0] && !flush_i;
         assign m_valid_o = vld[Stages-1] && !flush_i;
         assign m_data_o  = dat[Stages-1];
      end else begin : g_skid
         typedef enum logic {PASS, SKID} skid_state_e;

         logic                 mv  [Stages];
         logic [DataWidth-1:0] md  [Stages];
         logic                 rdy [Stages];

         for (genvar k = 0; k < Stages; k++) begin : g_stage
            logic                 in_vld;
            logic [DataWidth-1:0] in_dat;
            logic                 out_rdy;
            logic                 in_fire;
            logic                 out_fire;
            skid_state_e          state;
            logic                 rdy_q;
            logic                 mv_q;
            logic [DataWidth-1:0] md_q;
            logic [DataWidth-1:0] sd_q;

            if (k == 0) begin : g_head
               assign in_vld = s_valid_i;
               assign in_dat = s_data_i;
            end else begin : g_body
               assign in_vld = mv[k-1];
               assign in_dat = md[k-1];
            end

            if (k == Stages - 1) begin : g_tail
               assign out_rdy = m_ready_i;
            end else begin : g_mid
               assign out_rdy = rdy[k+1];
            end

            assign in_fire  = in_vld && rdy_q && !flush_i;
            assign out_fire = mv_q && out_rdy && !flush_i;

            // Skid slot absorbs the beat that arrives while main is stalled;
            // ready drops the following cycle since it only depends on state.
            always_ff @(posedge clk_i or posedge rst_i) begin
               if (rst_i) begin
                  state <= PASS;
                  rdy_q <= 1'b1;
                  mv_q  <= 1'b0;
                  md_q  <= '0;
                  sd_q  <= '0;
               end else if (flush_i) begin
                  state <= PASS;
                  rdy_q <= 1'b1;
                  mv_q  <= 1'b0;
               end else begin
                  case (state)
                     PASS: begin
                        if (in_fire) begin
                           if (!mv_q || out_fire) begin
                              mv_q <= 1'b1;
                              md_q <= in_dat;
                           end else begin
                              sd_q  <= in_dat;
                              state <= SKID;
                              rdy_q <= 1'b0;
                           end
                        end else if (out_fire) begin
                           mv_q <= 1'b0;
                        end
                     end
                     SKID: begin
                        if (out_fire) begin
                           md_q  <= sd_q;
                           state <= PASS;
                           rdy_q <= 1'b1;
                        end
                     end
                  endcase
               end
            end

            assign mv[k]  = mv_q;
            assign md[k]  = md_q;
            assign rdy[k] = rdy_q;
         end

         assign s_ready_o = rdy[0] && !flush_i;
         assign m_valid_o = mv[Stages-1] && !flush_i;
         assign m_data_o  = md[Stages-1];
      end

`ifdef AXIS_REG_CHAIN_LEVEL_EN
      if (Mode == 0) begin : g_level_none
         assign level_o = '0;
      end else begin : g_level
         localparam int LevelW = $clog2(2*Stages+1);
         logic [LevelW-1:0] level_q;
         logic              in_acc;
         logic              out_acc;

         assign in_acc  = s_valid_i && s_ready_o;
         assign out_acc = m_valid_o && m_ready_i;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               level_q <= '0;
            end else if (flush_i) begin
               level_q <= '0;
            end else if (in_acc && !out_acc) begin
               level_q <= level_q + LevelW'(1);
            end else if (!in_acc && out_acc) begin
               level_q <= level_q - LevelW'(1);
            end
         end

         assign level_o = level_q;
      end
`endif
   endgenerate

endmodule

// File: tb/tb_axis_reg_chain.sv
// Scoreboard bench for axis_reg_chain: instance 0 = Mode 0, 1 = Mode 1 (3 stages), 2 = Mode 2 (2 stages).
module tb_axis_reg_chain;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        s_valid [3];
   logic [15:0] s_data  [3];
   logic        s_ready [3];
   logic        m_ready [3];
   logic        m_valid [3];
   logic [15:0] m_data  [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          n_in      [3];
   int          n_out     [3];
   int          first_in  [3];
   int          first_out [3];
   int          last_out  [3];
   logic [15:0] first_data[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr(input int d);
      n_in[d]      = 0;
      n_out[d]     = 0;
      first_in[d]  = -1;
      first_out[d] = -1;
      last_out[d]  = -1;
      first_data[d] = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar i = 0; i < 3; i++) begin : g
      localparam int ST = (i == 1) ? 3 : 2;
      logic [15:0] q[$];
      logic        hold;
      logic [15:0] hold_data;
      logic [15:0] exp_data;
`ifdef AXIS_REG_CHAIN_LEVEL_EN
      logic [$clog2(2*ST+1)-1:0] lvl;
`endif

      axis_reg_chain #(.DataWidth(16), .Stages(ST), .Mode(i)) u_dut (
         .clk_i    (clk),
         .rst_i    (rst),
         .flush_i  (flush),
         .s_data_i (s_data[i]),
         .s_valid_i(s_valid[i]),
         .s_ready_o(s_ready[i]),
         .m_ready_i(m_ready[i]),
         .m_valid_o(m_valid[i]),
         .m_data_o (m_data[i])
`ifdef AXIS_REG_CHAIN_LEVEL_EN
         ,
         .level_o  (lvl)
`endif
      );

      // Reference: the chain is a FIFO of accepted-but-not-emitted beats.
      initial begin
         hold = 1'b0;
         hold_data = '0;
         forever begin
            @(negedge clk);
            if (rst) begin
               q.delete();
               hold = 1'b0;
            end else begin
               if (hold && !flush) begin
                  chk($sformatf("m%0d_hold_valid", i), 32'(m_valid[i]), 32'd1);
                  chk($sformatf("m%0d_hold_data", i), 32'(m_data[i]), 32'(hold_data));
               end
`ifdef AXIS_REG_CHAIN_LEVEL_EN
               chk($sformatf("m%0d_level", i), 32'(lvl), 32'(q.size()));
`endif
               if (flush && i != 0) q.delete();
               if (s_valid[i] && s_ready[i]) begin
                  q.push_back(s_data[i]);
                  n_in[i]++;
                  if (first_in[i] < 0) first_in[i] = cyc;
               end
               if (m_valid[i] && m_ready[i]) begin
                  if (q.size() == 0) begin
                     chk($sformatf("m%0d_unexpected_beat", i), 32'(m_valid[i]), 32'd0);
                  end else begin
                     exp_data = q.pop_front();
                     chk($sformatf("m%0d_data", i), 32'(m_data[i]), 32'(exp_data));
                  end
                  n_out[i]++;
                  if (first_out[i] < 0) begin
                     first_out[i]  = cyc;
                     first_data[i] = m_data[i];
                  end
                  last_out[i] = cyc;
               end
               hold      = (i != 0) && m_valid[i] && !m_ready[i];
               hold_data = m_data[i];
            end
         end
      end
   end

   task automatic rand_run(input int d, input int n);
      int   sent;
      int   budget;
      logic acc;
      sent   = 0;
      budget = 0;
      clr(d);
      s_valid[d] = 1'b0;
      while (sent < n && budget < 20000) begin
         @(negedge clk);
         acc = s_valid[d] && s_ready[d];
         @(posedge clk);
         #1;
         budget++;
         if (acc) sent++;
         if (!s_valid[d] || acc) begin
            s_valid[d] = (sent < n) && ($urandom_range(0, 1) == 1);
            s_data[d]  = 16'($urandom);
         end
         m_ready[d] = ($urandom_range(0, 1) == 1);
      end
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b1;
      repeat (20) tick();
      chk($sformatf("rand%0d_sent", d), 32'(sent), 32'(n));
      chk($sformatf("rand%0d_in", d), 32'(n_in[d]), 32'(n));
      chk($sformatf("rand%0d_out", d), 32'(n_out[d]), 32'(n));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc;
      rst   = 1'b1;
      flush = 1'b0;
      for (int d = 0; d < 3; d++) begin
         s_valid[d] = 1'b0;
         s_data[d]  = '0;
         m_ready[d] = 1'b0;
         clr(d);
      end
      repeat (3) tick();
      for (int d = 1; d < 3; d++) begin
         chk($sformatf("rst%0d_m_valid", d), 32'(m_valid[d]), 32'd0);
         chk($sformatf("rst%0d_m_data", d), 32'(m_data[d]), 32'd0);
         chk($sformatf("rst%0d_s_ready", d), 32'(s_ready[d]), 32'd1);
      end
      rst = 1'b0;
      tick();

      // Mode 1 streaming: latency equals stage count, no bubbles.
      clr(1);
      m_ready[1] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         s_data[1]  = 16'(k);
         s_valid[1] = 1'b1;
         tick();
      end
      s_valid[1] = 1'b0;
      repeat (8) tick();
      chk("m1_latency", 32'(first_out[1] - first_in[1]), 32'd3);
      chk("m1_beats_in", 32'(n_in[1]), 32'd16);
      chk("m1_beats_out", 32'(n_out[1]), 32'd16);
      chk("m1_no_bubbles", 32'(last_out[1] - first_out[1]), 32'd15);
      chk("m1_first_data", 32'(first_data[1]), 32'h0001);

      // Mode 2 fill under backpressure: capacity is 2*Stages.
      clr(2);
      m_ready[2] = 1'b0;
      nacc = 0;
      s_valid[2] = 1'b1;
      s_data[2]  = 16'hA000;
      repeat (10) begin
         @(negedge clk);
         if (s_valid[2] && s_ready[2]) nacc++;
         @(posedge clk);
         #1;
         s_data[2] = 16'(16'hA000 + nacc);
      end
      chk("m2_fill_count", 32'(nacc), 32'd4);
      chk("m2_full_ready", 32'(s_ready[2]), 32'd0);
      s_valid[2] = 1'b0;
      m_ready[2] = 1'b1;
      @(negedge clk);
      chk("m2_ready_c0", 32'(s_ready[2]), 32'd0);
      @(negedge clk);
      chk("m2_ready_c1", 32'(s_ready[2]), 32'd0);
      @(negedge clk);
      chk("m2_ready_c2", 32'(s_ready[2]), 32'd1);
      tick();
      repeat (6) tick();
      chk("m2_drain_count", 32'(n_out[2]), 32'd4);
      chk("m2_drain_first", 32'(first_data[2]), 32'hA000);

      // Random valid/ready traffic.
      rand_run(1, 1000);
      rand_run(2, 1000);

      // Mode 2 flush with three beats held and a competing input beat.
      clr(2);
      m_ready[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s_data[2]  = 16'(16'h1000 + k);
         s_valid[2] = 1'b1;
         tick();
      end
      flush      = 1'b1;
      s_data[2]  = 16'hBEEF;
      s_valid[2] = 1'b1;
      @(negedge clk);
      chk("flush_s_ready", 32'(s_ready[2]), 32'd0);
      chk("flush_m_valid", 32'(m_valid[2]), 32'd0);
      chk("flush_held", 32'(n_in[2]), 32'd3);
      tick();
      flush = 1'b0;
      clr(2);
      @(negedge clk);
      chk("post_flush_m_valid", 32'(m_valid[2]), 32'd0);
      chk("post_flush_s_ready", 32'(s_ready[2]), 32'd1);
`ifdef AXIS_REG_CHAIN_LEVEL_EN
      chk("post_flush_level", 32'(g[2].lvl), 32'd0);
`endif
      tick();
      s_valid[2] = 1'b0;
      m_ready[2] = 1'b1;
      repeat (6) tick();
      chk("flush_beef_count", 32'(n_out[2]), 32'd1);
      chk("flush_beef_data", 32'(first_data[2]), 32'hBEEF);

      // Asynchronous reset in the middle of a Mode 1 stream.
      clr(1);
      m_ready[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         s_data[1]  = 16'(16'h3000 + k);
         s_valid[1] = 1'b1;
         tick();
      end
      #2;
      rst        = 1'b1;
      s_valid[1] = 1'b0;
      #1;
      chk("arst_m_valid", 32'(m_valid[1]), 32'd0);
      chk("arst_m_data", 32'(m_data[1]), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      clr(1);
      repeat (3) tick();
      @(negedge clk);
      chk("arst_idle_valid", 32'(m_valid[1]), 32'd0);
      chk("arst_idle_count", 32'(n_out[1]), 32'd0);
      tick();
      s_data[1]  = 16'h5A5A;
      s_valid[1] = 1'b1;
      tick();
      s_valid[1] = 1'b0;
      repeat (6) tick();
      chk("arst_first_data", 32'(first_data[1]), 32'h5A5A);
      chk("arst_count", 32'(n_out[1]), 32'd1);

      // Mode 0: pure wires, flush has no effect.
      for (int k = 0; k < 8; k++) begin
         tick();
         s_valid[0] = ($urandom_range(0, 1) == 1);
         s_data[0]  = 16'($urandom);
         m_ready[0] = ($urandom_range(0, 1) == 1);
         flush      = (k % 2 == 1);
         #1;
         chk("m0_valid", 32'(m_valid[0]), 32'(s_valid[0]));
         chk("m0_data", 32'(m_data[0]), 32'(s_data[0]));
         chk("m0_ready", 32'(s_ready[0]), 32'(m_ready[0]));
         chk("m2_flush_gate", 32'(s_ready[2]), 32'(!flush));
      end
      tick();
      flush      = 1'b0;
      s_valid[0] = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
